mc_control: RTL and testbench

Multicycle sequencer for the LEGv8 datapath. It replaces the single-cycle main decoder when the core is built as a multicycle machine. It walks each instruction through FETCH, DECODE, EXEC, MEM and WB. Per state, it drives the same control set as the main decoder plus the PC/IR write enables, and stalls on a memory ready handshake. It sits between the instruction register and the shared register-file/ALU/memory datapath.

---
 rtl/mc_control.sv | 114 +++++++++++
 tb/tb_mc_control.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// mc_control: multicycle LEGv8 control sequencer (FETCH/DECODE/EXEC/MEM/WB) with memory-ready stalls.
// Optional retired-instruction counter enabled by defining MC_PERF_CNT_EN.
module mc_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        IRWrite,
  output logic        reg2loc,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic [1:0]  ALUOp,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        retired,
  output logic [31:0] instr_count
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4;
  localparam logic [2:0] C_R = 3'd0, C_CBZ = 3'd1, C_LD = 3'd2, C_ST = 3'd3, C_ILL = 3'd4;
  logic [2:0] state_q, next_state, cls_q, dec_cls, cls;
  always_comb
    dec_cls = (op == 11'b10001011000 || op == 11'b11001011000 ||
               op == 11'b10001010000 || op == 11'b10101010000) ? C_R :
              (op[10:3] == 8'b10110100) ? C_CBZ :
              (op == 11'b11111000010) ? C_LD :
              (op == 11'b11111000000) ? C_ST : C_ILL;
  // DECODE sees the live opcode; later states use the class latched at the DECODE edge
  assign cls = (state_q == DECODE) ? dec_cls : cls_q;
  assign state = state_q;
  always_comb begin
    next_state = FETCH;
    case (state_q)
      FETCH:   next_state = mem_ready ? DECODE : FETCH;
      DECODE:  next_state = (cls == C_ILL) ? FETCH : EXEC;
      EXEC:    next_state = (cls == C_CBZ) ? FETCH : (cls == C_R) ? WB : MEM;
      MEM:     next_state = !mem_ready ? MEM : (cls == C_LD) ? WB : FETCH;
      default: next_state = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= FETCH;
      cls_q   <= C_R;
    end else begin
      state_q <= next_state;
      if (state_q == DECODE) cls_q <= dec_cls;
    end
  // every control is held low while reset is asserted, even the FETCH read strobe
  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IRWrite  = 1'b0;
    reg2loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    ALUOp    = 2'b00;
    illegal  = 1'b0;
    retired  = 1'b0;
    if (reset)
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: begin
          reg2loc = (cls == C_CBZ) || (cls == C_ST);
          illegal = (cls == C_ILL);
        end
        EXEC: begin
          reg2loc = (cls == C_CBZ) || (cls == C_ST);
          ALUSrc  = (cls == C_LD) || (cls == C_ST);
          ALUOp   = (cls == C_R) ? 2'b10 : (cls == C_CBZ) ? 2'b01 : 2'b00;
          Branch  = (cls == C_CBZ);
          PCSrc   = (cls == C_CBZ);
          PCWrite = (cls == C_CBZ) && zero;
          retired = (cls == C_CBZ);
        end
        MEM: begin
          ALUSrc   = 1'b1;
          MemRead  = (cls == C_LD);
          MemWrite = (cls == C_ST);
          reg2loc  = (cls == C_ST);
          retired  = (cls == C_ST) && mem_ready;
        end
        WB: begin
          RegWrite = 1'b1;
          MemtoReg = (cls == C_LD);
          retired  = 1'b1;
        end
        default: ;
      endcase
  end
`ifdef MC_PERF_CNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (retired) cnt <= cnt + 32'd1;
  assign instr_count = cnt;
`else
  assign instr_count = '0;
`endif
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: table-driven per-cycle check of mc_control plus reset-abort and counter-wrap sequences.
module tb_mc_control;
  logic clk = 1'b0, reset = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic [10:0] op = '0;
  logic PCWrite, PCSrc, IRWrite, reg2loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic illegal, retired;
  logic [1:0] ALUOp;
  logic [2:0] state;
  logic [31:0] instr_count;

  mc_control dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .reg2loc(reg2loc), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .ALUOp(ALUOp), .state(state), .illegal(illegal), .retired(retired),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // {PCWrite,PCSrc,IRWrite,reg2loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp,illegal,retired}
  logic [13:0] ctl;
  assign ctl = {PCWrite, PCSrc, IRWrite, reg2loc, ALUSrc, MemtoReg, RegWrite, MemRead,
                MemWrite, Branch, ALUOp, illegal, retired};

  localparam logic [13:0] NONE   = 14'b00000000000000;
  localparam logic [13:0] F_RDY  = 14'b10100001000000;
  localparam logic [13:0] F_WAIT = 14'b00000001000000;
  localparam logic [13:0] D_RL   = 14'b00010000000000;
  localparam logic [13:0] D_ILL  = 14'b00000000000010;
  localparam logic [13:0] E_R    = 14'b00000000001000;
  localparam logic [13:0] E_LD   = 14'b00001000000000;
  localparam logic [13:0] E_ST   = 14'b00011000000000;
  localparam logic [13:0] E_CZ1  = 14'b11010000010101;
  localparam logic [13:0] E_CZ0  = 14'b01010000010101;
  localparam logic [13:0] M_LD   = 14'b00001001000000;
  localparam logic [13:0] M_STW  = 14'b00011000100000;
  localparam logic [13:0] M_STR  = 14'b00011000100001;
  localparam logic [13:0] W_R    = 14'b00000010000001;
  localparam logic [13:0] W_LD   = 14'b00000110000001;

  localparam logic [10:0] ADD = 11'b10001011000, SUB = 11'b11001011000, LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000, CBZ = 11'b10110100101, BAD = 11'b11111111111;

  typedef struct {
    logic [10:0] op;
    logic        zero;
    logic        mr;
    logic [2:0]  st;
    logic [13:0] ctl;
  } vec_t;

  vec_t v[30];
  int pass_n = 0, total_n = 0;
  logic [31:0] exp_cnt = '0;

  function automatic logic [31:0] ec(input logic [31:0] c);
`ifdef MC_PERF_CNT_EN
    return c;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    v[0]  = '{ADD,  1'b0, 1'b1, 3'd0, F_RDY};
    v[1]  = '{ADD,  1'b0, 1'b1, 3'd1, NONE};
    v[2]  = '{ADD,  1'b0, 1'b1, 3'd2, E_R};
    v[3]  = '{ADD,  1'b0, 1'b1, 3'd4, W_R};
    v[4]  = '{LDUR, 1'b0, 1'b1, 3'd0, F_RDY};
    v[5]  = '{LDUR, 1'b0, 1'b1, 3'd1, NONE};
    v[6]  = '{LDUR, 1'b0, 1'b1, 3'd2, E_LD};
    v[7]  = '{LDUR, 1'b0, 1'b0, 3'd3, M_LD};
    v[8]  = '{LDUR, 1'b0, 1'b0, 3'd3, M_LD};
    v[9]  = '{LDUR, 1'b0, 1'b1, 3'd3, M_LD};
    v[10] = '{LDUR, 1'b0, 1'b1, 3'd4, W_LD};
    v[11] = '{STUR, 1'b0, 1'b0, 3'd0, F_WAIT};
    v[12] = '{STUR, 1'b0, 1'b1, 3'd0, F_RDY};
    v[13] = '{STUR, 1'b0, 1'b1, 3'd1, D_RL};
    v[14] = '{STUR, 1'b0, 1'b1, 3'd2, E_ST};
    v[15] = '{STUR, 1'b0, 1'b0, 3'd3, M_STW};
    v[16] = '{STUR, 1'b0, 1'b1, 3'd3, M_STR};
    v[17] = '{CBZ,  1'b1, 1'b1, 3'd0, F_RDY};
    v[18] = '{CBZ,  1'b1, 1'b1, 3'd1, D_RL};
    v[19] = '{CBZ,  1'b1, 1'b1, 3'd2, E_CZ1};
    v[20] = '{CBZ,  1'b0, 1'b1, 3'd0, F_RDY};
    v[21] = '{CBZ,  1'b0, 1'b1, 3'd1, D_RL};
    v[22] = '{ADD,  1'b0, 1'b1, 3'd2, E_CZ0};
    v[23] = '{BAD,  1'b0, 1'b1, 3'd0, F_RDY};
    v[24] = '{BAD,  1'b0, 1'b1, 3'd1, D_ILL};
    v[25] = '{SUB,  1'b0, 1'b1, 3'd0, F_RDY};
    v[26] = '{SUB,  1'b0, 1'b0, 3'd1, NONE};
    v[27] = '{BAD,  1'b0, 1'b0, 3'd2, E_R};
    v[28] = '{LDUR, 1'b0, 1'b0, 3'd4, W_R};
    v[29] = '{ADD,  1'b0, 1'b0, 3'd0, F_WAIT};

    repeat (2) @(negedge clk);
    mem_ready = 1'b1;
    #2;
    chk("reset ctl/state", {15'd0, state, ctl}, 32'd0);
    chk("reset count", instr_count, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      op = v[i].op;
      zero = v[i].zero;
      mem_ready = v[i].mr;
      #2;
      chk($sformatf("row%0d ctl/state", i), {15'd0, state, ctl}, {15'd0, v[i].st, v[i].ctl});
      chk($sformatf("row%0d count", i), instr_count, ec(exp_cnt));
      if (v[i].ctl[0]) exp_cnt++;
      @(negedge clk);
    end

    // reset while LDUR waits in MEM abandons it
    op = LDUR;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #2;
    chk("abort pre ctl/state", {15'd0, state, ctl}, {15'd0, 3'd3, M_LD});
    reset = 1'b0;
    #1;
    chk("abort ctl/state", {15'd0, state, ctl}, 32'd0);
    chk("abort count", instr_count, 32'd0);
    @(negedge clk);
    mem_ready = 1'b1;
    #2;
    chk("held reset ctl/state", {15'd0, state, ctl}, 32'd0);
    reset = 1'b1;
    mem_ready = 1'b0;
    #2;
    chk("post reset ctl/state", {15'd0, state, ctl}, {15'd0, 3'd0, F_WAIT});
    @(negedge clk);
    chk("post reset wait", {15'd0, state, ctl}, {15'd0, 3'd0, F_WAIT});

    // counter wraps from all-ones to zero on the next retire
`ifdef MC_PERF_CNT_EN
    dut.cnt = 32'hFFFF_FFFF;
`endif
    op = ADD;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("wrap pre count", instr_count, ec(32'hFFFF_FFFF));
    chk("wrap wb ctl/state", {15'd0, state, ctl}, {15'd0, 3'd4, W_R});
    @(negedge clk);
    #2;
    chk("wrap count", instr_count, 32'd0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
